// File: rtl/memory_stage_pkg.sv
// Shared pipeline types for the Memory stage: FSM states and the EX/MEM and
// MEM/WB register layouts.
package memory_stage_pkg;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
    } memwb_t;

endpackage

// File: rtl/memory_stage_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; flags the last cycle
// the request may remain outstanding before it is declared timed out.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    input  logic advance,
    output logic at_limit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= CNT_W'(1);
        end else if (advance) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_stage.sv
// Pipeline Memory stage: EX/MEM register, valid/ready data-memory handshake
// with stall and timeout handling, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    input  logic        FlushM,
    output logic        StallM,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        AddrErr,
    output logic        BusErr
);

    exmem_t     ex_m;
    memwb_t     mw;
    mem_state_t state, state_next;

    logic mem_op, misal, timeout, drop, ret_valid, handshake;
    logic timer_start, timer_clear, timer_adv, at_limit;

    assign mem_op    = ex_m.valid & (ex_m.mem_to_reg | ex_m.mem_write);
    assign misal     = mem_op & (ex_m.alu_out[1:0] != 2'b00);
    assign handshake = mem_req & mem_ready;
    // The timeout cycle releases the stall so the dropped op leaves M.
    assign StallM    = mem_req & ~mem_ready & ~timeout;
    assign drop      = timeout | ((state == ERR) & mem_op);
    assign ret_valid = ex_m.valid & ~misal & ~drop;

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        timer_start = 1'b0;
        timer_clear = 1'b0;
        timer_adv   = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                mem_req = mem_op & ~misal;
                if (mem_op & ~misal & ~mem_ready) begin
                    state_next  = WAIT;
                    timer_start = 1'b1;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_next  = IDLE;
                    timer_clear = 1'b1;
                end else if (at_limit) begin
                    state_next  = ERR;
                    timer_clear = 1'b1;
                    timeout     = 1'b1;
                end else begin
                    timer_adv = 1'b1;
                end
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (timer_start),
        .clear    (timer_clear),
        .advance  (timer_adv),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_m <= '0;
        end else if (!StallM) begin
            ex_m.valid      <= ValidE & ~FlushM;
            ex_m.reg_write  <= RegWriteE;
            ex_m.mem_to_reg <= MemtoRegE;
            ex_m.mem_write  <= MemWriteE;
            ex_m.alu_out    <= ALUOutE;
            ex_m.write_data <= WriteDataE;
            ex_m.write_reg  <= WriteRegE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw <= '0;
        end else if (StallM) begin
            mw.valid      <= 1'b0;
            mw.reg_write  <= 1'b0;
            mw.mem_to_reg <= 1'b0;
        end else begin
            mw.valid      <= ret_valid;
            mw.reg_write  <= ex_m.reg_write & ret_valid;
            mw.mem_to_reg <= ex_m.mem_to_reg & ret_valid;
            mw.alu_out    <= ex_m.alu_out;
            mw.write_reg  <= ex_m.write_reg;
            if (handshake & ex_m.mem_to_reg) begin
                mw.read_data <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AddrErr <= 1'b0;
            BusErr  <= 1'b0;
        end else begin
            if (misal) begin
                AddrErr <= 1'b1;
            end
            if (timeout) begin
                BusErr <= 1'b1;
            end
        end
    end

    assign ALUOutM   = ex_m.alu_out;
    assign WriteRegM = ex_m.write_reg;
    assign RegWriteM = ex_m.valid & ex_m.reg_write;
    assign mem_we    = mem_req & ex_m.mem_write;
    assign mem_addr  = ex_m.alu_out;
    assign mem_wdata = ex_m.write_data;

    assign ValidW    = mw.valid;
    assign RegWriteW = mw.reg_write;
    assign MemtoRegW = mw.mem_to_reg;
    assign ReadDataW = mw.read_data;
    assign ALUOutW   = mw.alu_out;
    assign WriteRegW = mw.write_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: zero-wait vector table plus hand-written
// wait-state, flush, timeout and asynchronous-reset sequences.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, RegWriteE, MemtoRegE, MemWriteE, FlushM;
    logic [31:0] ALUOutE, WriteDataE;
    logic [4:0]  WriteRegE;
    logic        StallM, RegWriteM, mem_req, mem_we, mem_ready;
    logic [31:0] ALUOutM, mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  WriteRegM;
    logic        ValidW, RegWriteW, MemtoRegW, AddrErr, BusErr;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;

    int n_vec = 0;
    int n_bad = 0;

    memory_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .WriteRegE(WriteRegE), .FlushM(FlushM), .StallM(StallM),
        .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
        .AddrErr(AddrErr), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rw, m2r, mw, flush;
        logic [31:0] alu, wd, rdata;
        logic [4:0]  wreg;
        logic        req, we, vw, rww, aerr;
        logic [31:0] rdw;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_e(input logic v, input logic rw, input logic m2r, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg);
        ValidE = v; RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw;
        ALUOutE = alu; WriteDataE = wd; WriteRegE = wreg;
    endtask

    task automatic bubble_e();
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stalls;
        logic timed_out;

        //            v  rw m2r mw fl  alu           wd            rdata         wreg   req we vw rww aerr rdw
        vecs[0] = '{1, 1, 1, 0, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5'd8,  1, 0, 1, 1, 0, 32'hDEAD_BEEF};
        vecs[1] = '{1, 0, 0, 1, 0, 32'h0000_0204, 32'hCAFE_F00D, 32'h1111_1111, 5'd3,  1, 1, 1, 0, 0, 32'hDEAD_BEEF};
        vecs[2] = '{1, 1, 0, 0, 0, 32'h0000_0007, 32'h0,        32'h0,         5'd5,  0, 0, 1, 1, 0, 32'hDEAD_BEEF};
        vecs[3] = '{1, 1, 1, 0, 1, 32'h0000_0300, 32'h0,        32'h2222_2222, 5'd9,  0, 0, 0, 0, 0, 32'hDEAD_BEEF};
        vecs[4] = '{0, 0, 0, 1, 0, 32'h0000_0010, 32'h5A5A_5A5A, 32'h0,         5'd2,  0, 0, 0, 0, 0, 32'hDEAD_BEEF};
        vecs[5] = '{1, 0, 1, 0, 0, 32'h0000_0400, 32'h0,        32'h0BAD_F00D, 5'd0,  1, 0, 1, 0, 0, 32'h0BAD_F00D};
        vecs[6] = '{1, 1, 1, 0, 0, 32'h0000_0102, 32'h0,        32'h3333_3333, 5'd8,  0, 0, 0, 0, 1, 32'h0BAD_F00D};
        vecs[7] = '{1, 0, 0, 1, 0, 32'h0000_0201, 32'h7777_7777, 32'h0,         5'd1,  0, 0, 0, 0, 1, 32'h0BAD_F00D};
        vecs[8] = '{1, 1, 1, 0, 0, 32'h0000_0104, 32'h0,        32'h4444_4444, 5'd12, 1, 0, 1, 1, 1, 32'h4444_4444};

        rst_n = 1'b0;
        bubble_e();
        FlushM = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #3;
        chk("rst_stall", StallM, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_validw", ValidW, 0);
        chk("rst_readdataw", ReadDataW, 0);
        chk("rst_aluoutm", ALUOutM, 0);
        chk("rst_addrerr", AddrErr, 0);
        chk("rst_buserr", BusErr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait vectors: one instruction through M then W, bubbles behind it.
        foreach (vecs[k]) begin
            @(negedge clk);
            drive_e(vecs[k].v, vecs[k].rw, vecs[k].m2r, vecs[k].mw, vecs[k].alu, vecs[k].wd, vecs[k].wreg);
            FlushM = vecs[k].flush; mem_ready = 1'b1; mem_rdata = vecs[k].rdata;
            @(posedge clk); #1;
            bubble_e(); FlushM = 1'b0;
            #1;
            chk($sformatf("v%0d_req", k), mem_req, vecs[k].req);
            chk($sformatf("v%0d_we", k), mem_we, vecs[k].we);
            chk($sformatf("v%0d_stall", k), StallM, 0);
            chk($sformatf("v%0d_addr", k), mem_addr, vecs[k].alu);
            chk($sformatf("v%0d_wdata", k), mem_wdata, vecs[k].wd);
            @(posedge clk); #1;
            chk($sformatf("v%0d_validw", k), ValidW, vecs[k].vw);
            chk($sformatf("v%0d_regwritew", k), RegWriteW, vecs[k].rww);
            chk($sformatf("v%0d_readdataw", k), ReadDataW, vecs[k].rdw);
            chk($sformatf("v%0d_aluoutw", k), ALUOutW, vecs[k].alu);
            chk($sformatf("v%0d_writeregw", k), WriteRegW, vecs[k].wreg);
            chk($sformatf("v%0d_addrerr", k), AddrErr, vecs[k].aerr);
        end

        // Three-wait store with an ALU op queued behind it in E.
        @(negedge clk);
        drive_e(1, 0, 0, 1, 32'h200, 32'h1234_5678, 5'd0);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        drive_e(1, 1, 0, 0, 32'h55, 32'h0, 5'd6);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 3);
            #1;
            if (StallM) stalls++;
            chk("st_req", mem_req, 1);
            chk("st_addr", mem_addr, 32'h200);
            chk("st_wdata", mem_wdata, 32'h1234_5678);
            chk("st_validw", ValidW, 0);
            @(posedge clk); #1;
        end
        chk("st_stall_cycles", stalls, 3);
        chk("st_ret_validw", ValidW, 1);
        chk("st_ret_aluoutw", ALUOutW, 32'h200);
        chk("st_ret_regwritew", RegWriteW, 0);
        chk("st_next_aluoutm", ALUOutM, 32'h55);
        bubble_e();
        @(posedge clk); #1;
        chk("st_next_validw", ValidW, 1);
        chk("st_next_aluoutw", ALUOutW, 32'h55);
        chk("st_next_writeregw", WriteRegW, 6);

        // FlushM asserted while stalled must not abandon the pending load.
        @(negedge clk);
        drive_e(1, 1, 1, 0, 32'h500, 32'h0, 5'd10);
        mem_ready = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bubble_e(); FlushM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = (i == 2);
            if (i == 2) FlushM = 1'b0;
            #1;
            chk("fl_stall", StallM, (i < 2) ? 1 : 0);
            @(posedge clk); #1;
        end
        chk("fl_validw", ValidW, 1);
        chk("fl_regwritew", RegWriteW, 1);
        chk("fl_memtoregw", MemtoRegW, 1);
        chk("fl_readdataw", ReadDataW, 32'hA5A5_A5A5);
        chk("fl_writeregw", WriteRegW, 10);

        // Asynchronous reset in the second wait cycle, between clock edges.
        @(negedge clk);
        drive_e(1, 1, 1, 0, 32'hA00, 32'h0, 5'd13);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        bubble_e();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ar_req_before", mem_req, 1);
        chk("ar_stall_before", StallM, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_stall", StallM, 0);
        chk("ar_validw", ValidW, 0);
        chk("ar_readdataw", ReadDataW, 0);
        chk("ar_aluoutw", ALUOutW, 0);
        chk("ar_writeregw", WriteRegW, 0);
        chk("ar_addrerr", AddrErr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout: 15 stall cycles, op dropped, BusErr, later ops handled from ERR.
        @(negedge clk);
        drive_e(1, 1, 1, 0, 32'h700, 32'h0, 5'd11);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        drive_e(1, 1, 0, 0, 32'h7, 32'h0, 5'd4);
        stalls = 0; timed_out = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!StallM) begin
                timed_out = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        chk("to_reached", timed_out, 1);
        chk("to_stall_cycles", stalls, 15);
        chk("to_req_last", mem_req, 1);
        @(posedge clk); #1;
        chk("to_buserr", BusErr, 1);
        chk("to_drop_validw", ValidW, 0);
        chk("to_drop_regwritew", RegWriteW, 0);
        chk("to_alu_in_m", ALUOutM, 32'h7);
        chk("to_alu_req", mem_req, 0);
        drive_e(1, 1, 1, 0, 32'h800, 32'h0, 5'd14);
        @(posedge clk); #1;
        bubble_e();
        #1;
        chk("to_alu_validw", ValidW, 1);
        chk("to_alu_aluoutw", ALUOutW, 32'h7);
        chk("to_alu_writeregw", WriteRegW, 4);
        chk("to_load_req", mem_req, 0);
        chk("to_load_stall", StallM, 0);
        @(posedge clk); #1;
        chk("to_load_validw", ValidW, 0);
        chk("to_buserr_sticky", BusErr, 1);

        // mem_ready on the last allowed wait cycle: handshake wins.
        do_reset();
        drive_e(1, 1, 1, 0, 32'h900, 32'h0, 5'd15);
        mem_ready = 1'b0; mem_rdata = 32'h600D_CAFE;
        @(posedge clk); #1;
        bubble_e();
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mem_ready = (i == 15);
            #1;
            if (StallM) stalls++;
            @(posedge clk); #1;
        end
        chk("hw_stall_cycles", stalls, 15);
        chk("hw_buserr", BusErr, 0);
        chk("hw_validw", ValidW, 1);
        chk("hw_readdataw", ReadDataW, 32'h600D_CAFE);
        chk("hw_writeregw", WriteRegW, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
